// File: rtl/spram_arbiter.sv
// Shares the single-ported main SPRAM between the pipeline (port 0, fixed priority) and a secondary master (port 1).
// Grant and memory mux are combinational; read-valid follows one cycle after a granted read, aligned to the SPRAM output.
// A port 1 requester is denied while port 0 requests, until its wait count reaches MAX_WAIT; then it wins for one cycle.
module spram_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  p0_req,
    input  logic                  p0_write,
    input  logic [3:0]            p0_wmask,
    input  logic [31:0]           p0_wdata,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [31:0]           p0_rdata,

    input  logic                  p1_req,
    input  logic                  p1_write,
    input  logic [3:0]            p1_wmask,
    input  logic [31:0]           p1_wdata,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [31:0]           p1_rdata,

    output logic                  mem_write,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       p0_rvalid_q, p0_rvalid_d;
    logic       p1_rvalid_q, p1_rvalid_d;
    logic       starved;

    always_comb begin
        starved     = 1'b0;
        p0_gnt      = 1'b0;
        p1_gnt      = 1'b0;
        mem_addr    = p0_addr;
        mem_wdata   = p0_wdata;
        mem_wmask   = p0_wmask;
        mem_write   = p0_write & p0_req;
        wait_cnt_d  = wait_cnt_q;
        p0_rvalid_d = 1'b0;
        p1_rvalid_d = 1'b0;

        starved = (wait_cnt_q == MAX_WAIT_C) && p1_req;
        p1_gnt  = p1_req && (starved || !p0_req);
        p0_gnt  = p0_req && !starved;

        // Idle cycles keep port 0 on the bus so fetch addressing needs no grant first.
        if (p1_gnt) begin
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_wmask = p1_wmask;
            mem_write = p1_write & p1_req;
        end
        if (!mem_write) begin
            mem_wmask = 4'h0;
        end

        if (!p1_req || p1_gnt) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q < MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        p0_rvalid_d = p0_gnt & p0_req & ~p0_write;
        p1_rvalid_d = p1_gnt & p1_req & ~p1_write;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt_q  <= 8'd0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
        end
    end

    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = mem_rdata;
    assign p1_rdata  = mem_rdata;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with a behavioural byte-masked SPRAM (1-cycle read latency).
module tb_spram_arbiter;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          p0_req = 0, p0_write = 0, p1_req = 0, p1_write = 0;
    logic [3:0]    p0_wmask = 0, p1_wmask = 0;
    logic [31:0]   p0_wdata = 0, p1_wdata = 0;
    logic [AW-1:0] p0_addr = 0, p1_addr = 0;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0]   p0_rdata, p1_rdata;
    logic          mem_write;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = 0;

    logic [31:0]   mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_err = 0;

    spram_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(8)) dut (
        .clk(clk), .rstn(rstn),
        .p0_req(p0_req), .p0_write(p0_write), .p0_wmask(p0_wmask), .p0_wdata(p0_wdata),
        .p0_addr(p0_addr), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_write(p1_write), .p1_wmask(p1_wmask), .p1_wdata(p1_wdata),
        .p1_addr(p1_addr), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_write(mem_write), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic test_reset;
        p0_addr = 14'h1234;
        p1_addr = 14'h0ABC;
        p1_wmask = 4'hF;
        repeat (3) @(negedge clk);
        n_cmp++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b%b want 00", p0_rvalid, p1_rvalid); end
        rstn = 1'b1;
        #1;
        n_cmp++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin n_err++; $display("FAIL idle_gnt: got %b%b want 00", p0_gnt, p1_gnt); end
        n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL idle_mem_write: got %b want 0", mem_write); end
        n_cmp++; if (mem_wmask !== 4'h0) begin n_err++; $display("FAIL idle_mem_wmask: got %h want 0", mem_wmask); end
        n_cmp++; if (mem_addr !== 14'h1234) begin n_err++; $display("FAIL idle_mem_addr: got %h want 1234", mem_addr); end
        @(negedge clk);
        n_cmp++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin n_err++; $display("FAIL idle_rvalid: got %b%b want 00", p0_rvalid, p1_rvalid); end
    endtask

    task automatic test_p0_write_read;
        p0_req = 1; p0_write = 1; p0_addr = 14'h0010; p0_wdata = 32'hDEADBEEF; p0_wmask = 4'hF;
        #1;
        n_cmp++; if (p0_gnt !== 1'b1) begin n_err++; $display("FAIL p0_wr_gnt: got %b want 1", p0_gnt); end
        n_cmp++; if (mem_write !== 1'b1 || mem_wmask !== 4'hF) begin n_err++; $display("FAIL p0_wr_mem: got %b/%h want 1/f", mem_write, mem_wmask); end
        @(negedge clk);
        p0_write = 0;
        #1;
        n_cmp++; if (p0_gnt !== 1'b1) begin n_err++; $display("FAIL p0_rd_gnt: got %b want 1", p0_gnt); end
        n_cmp++; if (p0_rvalid !== 1'b0) begin n_err++; $display("FAIL p0_wr_no_rvalid: got %b want 0", p0_rvalid); end
        n_cmp++; if (mem_wmask !== 4'h0) begin n_err++; $display("FAIL p0_rd_wmask: got %h want 0", mem_wmask); end
        @(negedge clk);
        p0_req = 0;
        n_cmp++; if (p0_rvalid !== 1'b1) begin n_err++; $display("FAIL p0_rvalid: got %b want 1", p0_rvalid); end
        n_cmp++; if (p0_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL p0_rdata: got %h want deadbeef", p0_rdata); end
        @(negedge clk);
        n_cmp++; if (p0_rvalid !== 1'b0) begin n_err++; $display("FAIL p0_rvalid_one_cycle: got %b want 0", p0_rvalid); end
    endtask

    task automatic test_contention;
        logic exp1;
        p0_req = 1; p0_write = 0; p0_addr = 14'h0000;
        p1_req = 1; p1_write = 0; p1_addr = 14'h0001;
        for (int c = 0; c < 18; c++) begin
            #1;
            exp1 = (c == 8 || c == 17);
            n_cmp++; if (p1_gnt !== exp1) begin n_err++; $display("FAIL starve_p1_gnt c=%0d: got %b want %b", c, p1_gnt, exp1); end
            n_cmp++; if (p0_gnt !== !exp1) begin n_err++; $display("FAIL starve_p0_gnt c=%0d: got %b want %b", c, p0_gnt, !exp1); end
            if (c == 8) begin
                n_cmp++; if (mem_addr !== 14'h0001) begin n_err++; $display("FAIL starve_mem_addr: got %h want 0001", mem_addr); end
            end
            @(negedge clk);
        end
        p1_req = 0;
        @(negedge clk);
    endtask

    task automatic test_counter_clear;
        int  lat;
        bit  seen;
        p0_req = 1; p0_write = 0;
        p1_req = 1;
        repeat (4) @(negedge clk);
        p1_req = 0;
        @(negedge clk);
        p1_req = 1;
        lat = 0; seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            #1;
            if (p1_gnt === 1'b1) begin seen = 1; lat = k; end
            else @(negedge clk);
        end
        n_cmp++; if (!seen || lat != 8) begin n_err++; $display("FAIL counter_clear_latency: got %0d (seen=%0b) want 8", lat, seen); end
        @(negedge clk);
        p1_req = 0; p0_req = 0;
        @(negedge clk);
        p1_req = 1;
        #1;
        n_cmp++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin n_err++; $display("FAIL p1_uncontended: got %b%b want 01", p0_gnt, p1_gnt); end
        @(negedge clk);
        p1_req = 0;
        @(negedge clk);
    endtask

    task automatic test_byte_mask;
        p1_req = 1; p1_write = 1; p1_addr = 14'd5; p1_wdata = 32'h11223344; p1_wmask = 4'hF;
        @(negedge clk);
        p1_wdata = 32'hAABBCCDD; p1_wmask = 4'b0100;
        #1;
        n_cmp++; if (mem_wmask !== 4'b0100 || mem_wdata !== 32'hAABBCCDD) begin n_err++; $display("FAIL p1_mask_route: got %h/%h want 4/aabbccdd", mem_wmask, mem_wdata); end
        @(negedge clk);
        p1_write = 0; p1_wmask = 4'hF;
        #1;
        n_cmp++; if (mem_write !== 1'b0 || mem_wmask !== 4'h0) begin n_err++; $display("FAIL p1_read_wmask: got %b/%h want 0/0", mem_write, mem_wmask); end
        @(negedge clk);
        p1_req = 0;
        n_cmp++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h11BB3344) begin n_err++; $display("FAIL p1_masked_rdata: got %b/%h want 1/11bb3344", p1_rvalid, p1_rdata); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        p0_req = 1; p0_write = 1; p0_addr = 14'h0020; p0_wdata = 32'hA5A5_0001; p0_wmask = 4'hF;
        @(negedge clk);
        p0_req = 0;
        p1_req = 1; p1_write = 1; p1_addr = 14'h0021; p1_wdata = 32'h5A5A_0002; p1_wmask = 4'hF;
        @(negedge clk);
        p1_req = 0;
        p0_req = 1; p0_write = 0;
        @(negedge clk);
        p0_req = 0;
        p1_req = 1; p1_write = 0;
        n_cmp++; if (p0_rvalid !== 1'b1 || p1_rvalid !== 1'b0) begin n_err++; $display("FAIL ilv_n1_rvalid: got %b%b want 10", p0_rvalid, p1_rvalid); end
        n_cmp++; if (p0_rdata !== 32'hA5A5_0001) begin n_err++; $display("FAIL ilv_p0_rdata: got %h want a5a50001", p0_rdata); end
        #1;
        n_cmp++; if (p1_gnt !== 1'b1) begin n_err++; $display("FAIL ilv_p1_gnt: got %b want 1", p1_gnt); end
        @(negedge clk);
        p1_req = 0;
        n_cmp++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b1) begin n_err++; $display("FAIL ilv_n2_rvalid: got %b%b want 01", p0_rvalid, p1_rvalid); end
        n_cmp++; if (p1_rdata !== 32'h5A5A_0002) begin n_err++; $display("FAIL ilv_p1_rdata: got %h want 5a5a0002", p1_rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read;
        p1_req = 1; p1_write = 0; p1_addr = 14'h0021;
        #1;
        n_cmp++; if (p1_gnt !== 1'b1) begin n_err++; $display("FAIL rst_rd_gnt: got %b want 1", p1_gnt); end
        @(negedge clk);
        p1_req = 0;
        n_cmp++; if (p1_rvalid !== 1'b1) begin n_err++; $display("FAIL rst_pre_rvalid: got %b want 1", p1_rvalid); end
        rstn = 1'b0;
        #1;
        n_cmp++; if (p1_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_async_clear: got %b want 0", p1_rvalid); end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (p1_rvalid !== 1'b0 || p0_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_post_rvalid i=%0d: got %b%b want 00", i, p0_rvalid, p1_rvalid); end
        end
    endtask

    initial begin
        test_reset();
        test_p0_write_read();
        test_contention();
        test_counter_clear();
        test_byte_mask();
        test_back_to_back();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Two-requester arbiter that shares the single-ported 64 KiB main memory (two SB_SPRAM256KA halves, 1-cycle read latency) between the pipeline data/fetch port (port 0) and a secondary bus master such as a DMA or debug loader (port 1). Port 0 has fixed priority, and port 1 is protected from starvation by a bounded wait counter. The block sits between the requesters and the main memory wrapper. It routes address, write data and mask combinationally, and returns read-valid strobes aligned to the memory's registered output.

## Interface
Parameters:
- ADDR_WIDTH, default 14: word-address width; 14 bits select a 16K x 32 word.
- MAX_WAIT, default 8: number of consecutive denied cycles after which port 1 wins over port 0. Legal range is 1..255.

Ports:
- clk  in  1  single clock; every register is on its rising edge.
- rstn  in  1  reset, asynchronous and active-low.
- p0_req, p1_req  in  1  access request, held until granted.
- p0_write, p1_write  in  1  1 = write, 0 = read.
- p0_wmask, p1_wmask  in  4  byte-enable mask; only meaningful when the write input is 1.
- p0_wdata, p1_wdata  in  32  write data.
- p0_addr, p1_addr  in  ADDR_WIDTH  word address.
- p0_gnt, p1_gnt  out  1  combinational grant; the access happens in this cycle.
- p0_rvalid, p1_rvalid  out  1  registered; high in the cycle after a granted read.
- p0_rdata, p1_rdata  out  32  both driven from mem_rdata; valid only while the matching rvalid is high.
- mem_write  out  1  memory write enable.
- mem_wmask  out  4  memory byte mask.
- mem_wdata  out  32  memory write data.
- mem_addr  out  ADDR_WIDTH  memory word address.
- mem_rdata  in  32  memory read data, one cycle after the address.

## Operation
- Grant decision, combinational, every cycle:
  - If wait_cnt == MAX_WAIT and p1_req is high, grant port 1.
  - Otherwise, if p0_req is high, grant port 0.
  - Otherwise, if p1_req is high, grant port 1.
  - Otherwise, grant nothing.
- At most one gnt is high per cycle.
- Memory mux:
  - mem_addr, mem_wdata and mem_wmask come from the granted port.
  - When idle, they come from port 0, so an idle pipeline keeps zero-latency fetch addressing.
  - mem_write = granted port's write AND its req.
  - mem_wmask is forced to 0 whenever mem_write is 0.
- Starvation counter wait_cnt, 8 bits:
  - Increments by 1 in each cycle where p1_req=1 and p1_gnt=0.
  - Saturates at MAX_WAIT.
  - Clears to 0 in any cycle where p1_gnt=1 or p1_req=0.
- Read return:
  - pX_rvalid is set for exactly one cycle, the cycle after pX_gnt & pX_req & ~pX_write.
  - Writes never produce rvalid.
- Back-to-back:
  - A port may be granted in consecutive cycles.
  - A read grant in cycle n and any grant in cycle n+1 are both legal.
  - Each port's rvalid tracks its own grants independently.
- Requests from a port that is not granted are ignored; the requester must hold all of its request fields stable until gnt.

## Timing
- Reset (rstn=0, asynchronous):
  - wait_cnt=0, p0_rvalid=0, p1_rvalid=0.
  - Combinational outputs follow their inputs; gnt, mem_write and mem_wmask are 0 while no req is high.
- Reset asserted mid-read:
  - The pending rvalid is cleared immediately and is never reported after reset release.
  - The memory content of an already-granted write is undefined only if rstn falls in the same cycle.
- Latency:
  - Grant is in the same cycle as the request when uncontended.
  - Read data arrives at cycle grant+1.
  - The worst-case port 1 grant occurs at cycle MAX_WAIT after the request is raised, under a continuous port 0 request.
- Port 0 worst-case stall is 1 cycle per MAX_WAIT+1 cycles while port 1 is saturating.
- Simultaneous events:
  - Both req high with wait_cnt < MAX_WAIT: port 0 wins and wait_cnt increments.
  - At wait_cnt == MAX_WAIT: port 1 wins and the counter clears to 0 on the next edge.
- Counter wrap: wait_cnt never exceeds MAX_WAIT; there is no wrap past 255.

## Test plan
- Reset and idle:
  - Hold rstn=0 for 3 cycles with all req=0, then release.
  - Required: all gnt=0, rvalid=0, mem_write=0, mem_wmask=0, and mem_addr=p0_addr.
- Single-port write then read:
  - Port 0 writes 32'hDEADBEEF to addr 14'h0010 with mask 4'hF, then reads it back.
  - Required: p0_gnt is high both cycles, p0_rvalid is high exactly one cycle after the read, and p0_rdata=32'hDEADBEEF.
- Contention with starvation (MAX_WAIT=8):
  - Hold p0_req=1 (reads) continuously and raise p1_req at cycle 0.
  - Required: p1_gnt is first high at cycle 8, p0_gnt is low at cycle 8, and wait_cnt returns to 0.
- Byte mask:
  - Port 1 writes 32'h11223344 to addr 5, then writes 32'hAABBCCDD with mask 4'b0100, then reads addr 5.
  - Required: p1_rdata=32'h11BB3344.
- Interleaved reads:
  - Port 0 reads in cycle n and port 1 reads in cycle n+1, from different addresses.
  - Required: p0_rvalid is high in n+1, p1_rvalid is high in n+2, each rdata is correct, and rvalid never overlaps with the wrong port.
- Reset mid-read:
  - Grant a port 1 read, then pull rstn low half a cycle later.
  - Required: p1_rvalid goes to 0 immediately and stays 0 after release until a new grant.
